// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the memory responder.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int          WAIT_CNT_W = 4;
    localparam logic [31:0] ERR_DATA   = 32'h0000_0000;

endpackage

// File: rtl/mem_array_sp.sv
// Single-port word storage: synchronous write, combinational read, no reset.
module mem_array_sp #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side target for the CPU port: one request at a time, programmable
// wait states, one-cycle ready pulse, flags misaligned/out-of-range accesses.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] write_data_mem,
    output logic [31:0] mem_data,
    output logic        mem_ready,
    output logic        mem_busy,
    output logic        addr_err
);

    localparam int ADDR_W = $clog2(DEPTH_WORDS);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

    // Word aligned and inside the power-of-two storage window.
    function automatic logic addr_legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a[31:ADDR_W+2] == '0);
    endfunction

    state_t                state;
    state_t                state_nxt;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic                  accept;
    logic                  enter_resp;

    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_rd;
    logic        req_wr;

    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic        acc_rd;
    logic        acc_wr;
    logic        acc_legal;
    logic        arr_we;
    logic [31:0] arr_rdata;

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        enter_resp = 1'b0;
        unique case (state)
            IDLE: begin
                if (mem_read || mem_write) begin
                    accept = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_nxt  = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt == '0) begin
                    state_nxt  = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // With zero wait states the access happens on the accepting edge, so the
    // live request is used instead of the (not yet loaded) request registers.
    assign acc_addr  = (state == IDLE) ? mem_addr       : req_addr;
    assign acc_wdata = (state == IDLE) ? write_data_mem : req_wdata;
    assign acc_rd    = (state == IDLE) ? mem_read       : req_rd;
    assign acc_wr    = (state == IDLE) ? mem_write      : req_wr;
    assign acc_legal = addr_legal(acc_addr);
    assign arr_we    = enter_resp && acc_wr && acc_legal;

    mem_array_sp #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .addr  (acc_addr[ADDR_W+1:2]),
        .wdata (acc_wdata),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk) begin
        if (accept) begin
            req_addr  <= mem_addr;
            req_wdata <= write_data_mem;
            req_rd    <= mem_read;
            req_wr    <= mem_write;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            mem_data  <= '0;
            mem_ready <= 1'b0;
            mem_busy  <= 1'b0;
            addr_err  <= 1'b0;
        end else begin
            state     <= state_nxt;
            mem_ready <= (state == RESP);
            addr_err  <= (state == RESP) && !addr_legal(req_addr);

            if (accept) begin
                mem_busy <= 1'b1;
            end else if (state == RESP) begin
                mem_busy <= 1'b0;
            end

            if (accept) begin
                wait_cnt <= WAIT_LOAD;
            end else if ((state == WAIT) && (wait_cnt != '0)) begin
                wait_cnt <= wait_cnt - 1'b1;
            end

            // Read data is captured alongside the write, so it is the old word.
            if (enter_resp) begin
                if (!acc_legal) begin
                    mem_data <= ERR_DATA;
                end else if (acc_rd) begin
                    mem_data <= arr_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder at WAIT_STATES 0, 1 and 2 against a transaction-level model.
module tb_mem_responder;

    localparam int DEPTH = 256;

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] data;
        bit          chk;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input int id, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL ws%0d %s: got %h expected %h (cycle %0d)", id, name, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : ws
        localparam int WS = g;

        logic        rst_n = 1'b1;
        logic [31:0] addr, wdata, rdata;
        logic        rd, wr, ready, busy, err;
        bit          armed = 1'b0;
        bit          done = 1'b0;

        logic [31:0] mem_m [DEPTH];
        bit          known [DEPTH];
        exp_t        q[$];
        int          next_free = 0;
        int          busy_lo = 1;
        int          busy_hi = 0;

        mem_responder #(
            .DEPTH_WORDS (DEPTH),
            .WAIT_STATES (WS)
        ) dut (
            .clk            (clk),
            .reset          (rst_n),
            .mem_addr       (addr),
            .mem_read       (rd),
            .mem_write      (wr),
            .write_data_mem (wdata),
            .mem_data       (rdata),
            .mem_ready      (ready),
            .mem_busy       (busy),
            .addr_err       (err)
        );

        // Request accepted at edge e: busy for cycles e..e+WS, ready in cycle e+WS+1.
        function automatic void model_accept(input int e, input bit r, input bit w,
                                             input logic [31:0] a, input logic [31:0] d,
                                             input bit commit);
            exp_t x;
            int   idx;
            bit   legal;
            legal  = (a % 4 == 0) && ((a / 4) < 32'(DEPTH));
            x.cyc  = e + WS + 1;
            x.err  = !legal;
            x.data = 32'h0;
            x.chk  = !legal;
            if (legal) begin
                idx = int'(a / 4);
                if (r) begin
                    x.data = mem_m[idx];
                    x.chk  = known[idx];
                end
                if (w && commit) begin
                    mem_m[idx] = d;
                    known[idx] = 1'b1;
                end
            end
            q.push_back(x);
            next_free = e + WS + 2;
            busy_lo   = e;
            busy_hi   = e + WS;
        endfunction

        task automatic drive_idle(input bit noise);
            if (noise) begin
                rd    = 1'($urandom);
                wr    = 1'($urandom);
                addr  = $urandom;
                wdata = $urandom;
            end else begin
                rd = 1'b0;
                wr = 1'b0;
            end
        endtask

        // Called at a negedge; returns at the negedge where ready is seen.
        task automatic req(input bit r, input bit w, input logic [31:0] a,
                           input logic [31:0] d, input bit noise,
                           output logic [31:0] got, output logic gerr,
                           output int lat, output int acc, output int nbusy);
            bit seen;
            while (cyc + 1 < next_free) begin
                drive_idle(noise);
                @(negedge clk);
            end
            rd = r; wr = w; addr = a; wdata = d;
            acc = cyc + 1;
            model_accept(acc, r, w, a, d, 1'b1);
            seen = 1'b0; lat = -1; got = '0; gerr = 1'b0; nbusy = 0;
            for (int k = 0; k < 40 && !seen; k++) begin
                @(negedge clk);
                if (busy) nbusy++;
                if (ready) begin
                    seen = 1'b1; got = rdata; gerr = err; lat = cyc - acc;
                    rd = 1'b0; wr = 1'b0;
                end else begin
                    drive_idle(noise);
                end
            end
            if (!seen) chk(WS, "ready_timeout", 32'(seen), 32'd1);
        endtask

        task automatic pulse_reset(input int ncyc);
            #2 rst_n = 1'b0;
            armed = 1'b1;
            q.delete();
            busy_lo = 1; busy_hi = 0;
            rd = 1'b0; wr = 1'b0;
            repeat (ncyc) @(negedge clk);
            #2 rst_n = 1'b1;
            next_free = 0;
            @(negedge clk);
        endtask

        always @(negedge clk) begin
            exp_t x;
            bit   exp_rdy;
            if (armed) begin
                if (!rst_n) begin
                    chk(WS, "rst_ready", 32'(ready), 32'd0);
                    chk(WS, "rst_busy",  32'(busy),  32'd0);
                    chk(WS, "rst_err",   32'(err),   32'd0);
                    chk(WS, "rst_data",  rdata,      32'd0);
                end else begin
                    while (q.size() > 0 && q[0].cyc < cyc) void'(q.pop_front());
                    exp_rdy = (q.size() > 0) && (q[0].cyc == cyc);
                    chk(WS, "ready", 32'(ready), 32'(exp_rdy));
                    chk(WS, "busy", 32'(busy), 32'((cyc >= busy_lo) && (cyc <= busy_hi)));
                    if (exp_rdy) begin
                        x = q.pop_front();
                        chk(WS, "addr_err", 32'(err), 32'(x.err));
                        if (x.chk) chk(WS, "mem_data", rdata, x.data);
                    end else begin
                        chk(WS, "err_idle", 32'(err), 32'd0);
                    end
                end
            end
        end

        initial begin
            logic [31:0] got;
            logic        gerr;
            int          lat, acc0, acc1, nb;
            rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
            for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
            @(negedge clk);
            pulse_reset(2);

            req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, got, gerr, lat, acc0, nb);
            chk(WS, "wr10_lat", 32'(lat), 32'(WS + 1));
            chk(WS, "wr10_busy_cycles", 32'(nb), 32'(WS + 1));
            chk(WS, "wr10_err", 32'(gerr), 32'd0);
            req(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, got, gerr, lat, acc0, nb);
            chk(WS, "rd10_data", got, 32'hDEADBEEF);
            chk(WS, "rd10_err", 32'(gerr), 32'd0);
            chk(WS, "rd10_lat", 32'(lat), 32'(WS + 1));
            req(1'b1, 1'b0, 32'h12, 32'h0, 1'b0, got, gerr, lat, acc0, nb);
            chk(WS, "misalign_err", 32'(gerr), 32'd1);
            chk(WS, "misalign_data", got, 32'h0);

            req(1'b0, 1'b1, 32'h0, 32'h11111111, 1'b0, got, gerr, lat, acc0, nb);
            req(1'b0, 1'b1, 32'h400, 32'hCAFEF00D, 1'b1, got, gerr, lat, acc0, nb);
            chk(WS, "range_err", 32'(gerr), 32'd1);
            req(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, got, gerr, lat, acc0, nb);
            chk(WS, "no_alias", got, 32'h11111111);

            req(1'b0, 1'b1, 32'h80, 32'h12345678, 1'b0, got, gerr, lat, acc0, nb);
            req(1'b1, 1'b1, 32'h80, 32'hAAAA5555, 1'b0, got, gerr, lat, acc0, nb);
            chk(WS, "rbw_old", got, 32'h12345678);
            chk(WS, "rbw_err", 32'(gerr), 32'd0);
            req(1'b1, 1'b0, 32'h80, 32'h0, 1'b0, got, gerr, lat, acc0, nb);
            chk(WS, "rbw_new", got, 32'hAAAA5555);

            // Reset in the cycle after acceptance: only the zero-wait variant has written.
            req(1'b0, 1'b1, 32'h30, 32'h0BADF00D, 1'b0, got, gerr, lat, acc0, nb);
            while (cyc + 1 < next_free) @(negedge clk);
            rd = 1'b0; wr = 1'b1; addr = 32'h30; wdata = 32'hFFFFFFFF;
            model_accept(cyc + 1, 1'b0, 1'b1, 32'h30, 32'hFFFFFFFF, WS == 0);
            @(negedge clk);
            wr = 1'b0;
            pulse_reset(2);
            req(1'b1, 1'b0, 32'h30, 32'h0, 1'b0, got, gerr, lat, acc0, nb);
            chk(WS, "rst_mid_op", got, (WS == 0) ? 32'hFFFFFFFF : 32'h0BADF00D);

            req(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, got, gerr, lat, acc0, nb);
            chk(WS, "b2b_data0", got, 32'h11111111);
            req(1'b1, 1'b0, 32'h4, 32'h0, 1'b1, got, gerr, lat, acc1, nb);
            chk(WS, "b2b_interval", 32'(acc1 - acc0), 32'(WS + 2));
            chk(WS, "b2b_lat", 32'(lat), 32'(WS + 1));

            for (int n = 0; n < 120; n++) begin
                bit          r, w;
                logic [31:0] a;
                int          sel;
                sel = int'($urandom_range(0, 9));
                a = 32'($urandom_range(0, 15)) << 2;
                if (sel == 7) a = ($urandom_range(0, 1) == 0) ? 32'((DEPTH - 1) * 4) : 32'(DEPTH * 4);
                else if (sel == 8) a = a | 32'($urandom_range(1, 3));
                else if (sel == 9) a = $urandom | 32'h0001_0000;
                case ($urandom_range(0, 2))
                    0:       begin r = 1'b1; w = 1'b0; end
                    1:       begin r = 1'b0; w = 1'b1; end
                    default: begin r = 1'b1; w = 1'b1; end
                endcase
                req(r, w, a, $urandom, 1'($urandom), got, gerr, lat, acc0, nb);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            done = 1'b1;
        end
    end

    initial begin
        bit all_done;
        all_done = 1'b0;
        for (int k = 0; k < 60000 && !all_done; k++) begin
            @(posedge clk);
            all_done = ws[0].done && ws[1].done && ws[2].done;
        end
        if (!all_done) begin
            checks++;
            failures++;
            $display("FAIL run_timeout: got unfinished expected all instances done");
        end
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
